// File: rtl/my_cpu_mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: RV32I opcode fields
// (instruction[6:2]), state encoding and opcode classes.
package my_cpu_mc_sequencer_pkg;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } mc_state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_UPPER
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] opcode);
    op_class_e cls;
    case (opcode)
      OPCODE_OP, OPCODE_OP_IMM: cls = CLS_ALU;
      OPCODE_LOAD:              cls = CLS_LOAD;
      OPCODE_STORE:             cls = CLS_STORE;
      OPCODE_BRANCH:            cls = CLS_BRANCH;
      OPCODE_JAL, OPCODE_JALR:  cls = CLS_JUMP;
      OPCODE_LUI, OPCODE_AUIPC: cls = CLS_UPPER;
      default:                  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/my_cpu_mc_sequencer_waittimer.sv
// Memory-wait counter: counts unacknowledged request cycles and flags the
// cycle in which the count would reach TIMEOUT.
module my_cpu_mc_waittimer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= 8'd0;
    end else if (en) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // This cycle is the TIMEOUT-th unacknowledged one.
  assign timeout = en && (count_reg == LIMIT);

endmodule

// File: rtl/my_cpu_mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with
// memory timeouts, sticky error flags and a retired-instruction counter.
module my_cpu_mc_sequencer
  import my_cpu_mc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  OPcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWriteEn,
  output logic [2:0]  state,
  output logic        bus_err,
  output logic        ill_err,
  output logic [31:0] instret
);

  mc_state_e   state_reg, state_next;
  op_class_e   op_class;
  logic        bus_err_reg, ill_err_reg;
  logic        bus_err_set, ill_err_set;
  logic [31:0] instret_reg;
  logic        wait_clr, wait_en, wait_timeout;
  logic        imem_req_c, dmem_req_c, ir_write_c, pc_write_c, reg_write_c;

  assign op_class = classify(OPcode);

  assign wait_en = !rst && (((state_reg == ST_FETCH) && !imem_ack) ||
                            ((state_reg == ST_MEM)   && !dmem_ack));
  assign wait_clr = (state_next != state_reg) &&
                    ((state_next == ST_FETCH) || (state_next == ST_MEM));

  my_cpu_mc_waittimer #(.TIMEOUT(TIMEOUT)) u_waittimer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .en      (wait_en),
    .timeout (wait_timeout)
  );

  always_comb begin
    state_next  = state_reg;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    bus_err_set = 1'b0;
    ill_err_set = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_write_c = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_timeout) begin
          bus_err_set = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (op_class == CLS_ILLEGAL) begin
          ill_err_set = 1'b1;
          state_next  = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_BRANCH: begin
            pc_write_c = 1'b1;
            state_next = ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ack) begin
          if (op_class == CLS_LOAD) begin
            state_next = ST_WB;
          end else begin
            pc_write_c = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (wait_timeout) begin
          bus_err_set = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      bus_err_reg <= 1'b0;
      ill_err_reg <= 1'b0;
      instret_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (bus_err_set) bus_err_reg <= 1'b1;
      if (ill_err_set) ill_err_reg <= 1'b1;
      if (pc_write_c)  instret_reg <= instret_reg + 32'd1;
    end
  end

  // Reset masks every strobe so an abandoned access never commits.
  assign imem_req   = imem_req_c  && !rst;
  assign dmem_req   = dmem_req_c  && !rst;
  assign IRWrite    = ir_write_c  && !rst;
  assign PCWrite    = pc_write_c  && !rst;
  assign RegWriteEn = reg_write_c && !rst;
  assign state      = state_reg;
  assign bus_err    = bus_err_reg;
  assign ill_err    = ill_err_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_my_cpu_mc_sequencer.sv
// Randomized self-checking bench: each instruction's expected cycle trace is
// built from the opcode class and the chosen memory wait counts.
module tb_my_cpu_mc_sequencer;

  localparam int T = 15;

  logic        clk;
  logic        rst;
  logic [4:0]  OPcode;
  logic        imem_req, imem_ack, dmem_req, dmem_ack;
  logic        IRWrite, PCWrite, RegWriteEn;
  logic [2:0]  state;
  logic        bus_err, ill_err;
  logic [31:0] instret;

  my_cpu_mc_sequencer #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .OPcode     (OPcode),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWriteEn (RegWriteEn),
    .state      (state),
    .bus_err    (bus_err),
    .ill_err    (ill_err),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic ireq, dreq, irw, pcw, rwe;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic iack;
    logic dack;
  } step_t;

  step_t       trace[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] instret_model = 0;

  // Instruction classes: 0 illegal, 1 load, 2 store, 3 branch, 4 register-writing
  function automatic int op_kind(input logic [4:0] op);
    case (op)
      5'b00000: return 1;
      5'b01000: return 2;
      5'b11000: return 3;
      5'b01100, 5'b00100, 5'b11001, 5'b11011, 5'b01101, 5'b00101: return 4;
      default:  return 0;
    endcase
  endfunction

  function automatic step_t mk(input int st, input bit ireq, input bit dreq, input bit irw,
                               input bit pcw, input bit rwe, input bit iack, input bit dack);
    step_t s;
    s.o.st = 3'(st); s.o.ireq = ireq; s.o.dreq = dreq; s.o.irw = irw;
    s.o.pcw = pcw; s.o.rwe = rwe; s.iack = iack; s.dack = dack;
    return s;
  endfunction

  // outcome: 0 retires, 1 halts on illegal opcode, 2 halts on bus timeout
  task automatic build_trace(input logic [4:0] op, input int fw, input int mw, output int outcome);
    int k;
    k = op_kind(op);
    trace.delete();
    for (int i = 0; i < fw && i < T; i++) trace.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    if (fw >= T) begin outcome = 2; return; end
    trace.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0));
    trace.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    if (k == 0) begin outcome = 1; return; end
    if (k == 3) begin trace.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0)); outcome = 0; return; end
    trace.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0));
    if (k == 1 || k == 2) begin
      for (int i = 0; i < mw && i < T; i++) trace.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0));
      if (mw >= T) begin outcome = 2; return; end
      trace.push_back(mk(3, 0, 1, 0, (k == 2), 0, 0, 1));
      if (k == 2) begin outcome = 0; return; end
    end
    trace.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0));
    outcome = 0;
  endtask

  // Drives one cycle from a negedge; acks on idle request lines are random noise.
  task automatic drive_step(input step_t s, output obs_t got);
    imem_ack = s.o.ireq ? s.iack : 1'($urandom_range(0, 1));
    dmem_ack = s.o.dreq ? s.dack : 1'($urandom_range(0, 1));
    #1;
    got = {state, imem_req, dmem_req, IRWrite, PCWrite, RegWriteEn};
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    instret_model = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    OPcode = 5'b01100;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++;
    if ({imem_req, dmem_req, IRWrite, PCWrite, RegWriteEn} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=00000",
                      {imem_req, dmem_req, IRWrite, PCWrite, RegWriteEn});
    end
    total++;
    if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
    total++;
    if ({bus_err, ill_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus_err, ill_err}); end
    @(negedge clk);
    rst = 1'b0;
    instret_model = 0;
    $display("reset: state=%0d instret=%0d", state, instret);
  endtask

  task automatic test_instr(input string name, input logic [4:0] op, input int fw, input int mw);
    int   outcome;
    obs_t got;
    obs_t halt_o;
    OPcode = op;
    build_trace(op, fw, mw, outcome);
    foreach (trace[i]) begin
      drive_step(trace[i], got);
      total++;
      if (got !== trace[i].o) begin
        bad++;
        $display("FAIL %s step %0d got=%b want=%b (st,ireq,dreq,irw,pcw,rwe)", name, i, got, trace[i].o);
      end
    end
    if (outcome == 0) begin
      instret_model++;
      total++;
      if (instret !== instret_model) begin
        bad++; $display("FAIL %s instret got=%0d want=%0d", name, instret, instret_model);
      end
      total++;
      if ({bus_err, ill_err} !== 2'b00) begin
        bad++; $display("FAIL %s flags got=%b want=00", name, {bus_err, ill_err});
      end
    end else begin
      halt_o = '0;
      halt_o.st = 3'd5;
      total++;
      if ({bus_err, ill_err} !== {1'(outcome == 2), 1'(outcome == 1)}) begin
        bad++; $display("FAIL %s halt_flags got=%b want=%b", name, {bus_err, ill_err},
                        {1'(outcome == 2), 1'(outcome == 1)});
      end
      repeat (4) begin
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        got = {state, imem_req, dmem_req, IRWrite, PCWrite, RegWriteEn};
        total++;
        if (got !== halt_o || instret !== instret_model ||
            {bus_err, ill_err} !== {1'(outcome == 2), 1'(outcome == 1)}) begin
          bad++; $display("FAIL %s halt_hold got=%b want=%b instret=%0d want=%0d", name, got, halt_o,
                          instret, instret_model);
        end
        @(negedge clk);
      end
    end
    $display("instr %s op=%b fw=%0d mw=%0d cycles=%0d outcome=%0d instret=%0d",
             name, op, fw, mw, trace.size(), outcome, instret);
    if (outcome != 0) do_reset();
  endtask

  task automatic test_directed();
    test_instr("add",   5'b01100, 0, 0);
    test_instr("lw_w3", 5'b00000, 0, 3);
    test_instr("beq",   5'b11000, 0, 0);
    test_instr("sw",    5'b01000, 0, 0);
    test_instr("jal",   5'b11011, 2, 0);
    test_instr("lui",   5'b01101, 0, 0);
  endtask

  task automatic test_illegal();
    test_instr("illegal", 5'b11111, 0, 0);
    test_instr("illegal_sys", 5'b11100, 1, 0);
  endtask

  task automatic test_timeout();
    test_instr("fetch_ack15",  5'b01100, T - 1, 0);
    test_instr("fetch_tmo",    5'b01100, T, 0);
    test_instr("mem_ack15",    5'b00000, 0, T - 1);
    test_instr("mem_tmo",      5'b01000, 0, T);
  endtask

  task automatic test_back_to_back();
    logic [4:0] legal_ops[9];
    logic [4:0] op;
    int fw, mw;
    legal_ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                  5'b11001, 5'b11011, 5'b01101, 5'b00101};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
      else op = legal_ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, T)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, T)) : int'($urandom_range(0, 3));
      test_instr("rand", op, fw, mw);
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t got;
    int   outcome;
    do_reset();
    OPcode = 5'b01000;
    build_trace(5'b01000, 0, 5, outcome);
    for (int i = 0; i < 4; i++) begin
      drive_step(trace[i], got);
      total++;
      if (got !== trace[i].o) begin
        bad++; $display("FAIL rst_mem step %0d got=%b want=%b", i, got, trace[i].o);
      end
    end
    rst = 1'b1;
    dmem_ack = 1'b1;
    imem_ack = 1'b0;
    #1;
    total++;
    if ({imem_req, dmem_req, IRWrite, PCWrite, RegWriteEn} !== 5'b0) begin
      bad++; $display("FAIL rst_mem_strobes got=%b want=00000",
                      {imem_req, dmem_req, IRWrite, PCWrite, RegWriteEn});
    end
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL rst_mem_state got st=%0d ireq=%b want st=0 ireq=1", state, imem_req);
    end
    total++;
    if (instret !== 32'd0) begin bad++; $display("FAIL rst_mem_instret got=%0d want=0", instret); end
    $display("reset_mid_mem: state=%0d instret=%0d", state, instret);
    @(negedge clk);
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    OPcode = 5'b0;
    test_reset();
    test_directed();
    test_illegal();
    test_timeout();
    do_reset();
    test_back_to_back();
    test_reset_mid_mem();
    test_instr("after_rst", 5'b00100, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
